// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// Gated-window frequency meter: counts synchronized rising edges of sig_in over
// GATE_CYCLES clocks, then publishes the count with a one-cycle done pulse.
module freq_meter #(
    parameter int GATE_CYCLES = 48000000,
    parameter int GATE_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] freq_out,
    output logic                 done,
    output logic                 ovf,
    output logic                 busy
);

    localparam logic [GATE_WIDTH-1:0] GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        LATCH
    } state_t;

    state_t                state;
    logic                  sync1;
    logic                  sync2;
    logic                  sync3;
    logic                  rise;
    logic [GATE_WIDTH-1:0] gate_cnt;
    logic [CNT_WIDTH-1:0]  edge_cnt;
    logic                  sat;

    // sync1/sync2 resolve metastability; sync3 only delays for edge detection.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            freq_out <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (en) begin
                        state <= GATE;
                        busy  <= 1'b1;
                    end
                end
                GATE: begin
                    if (!en) begin
                        // Abort: partial window is discarded, published result is kept.
                        state    <= IDLE;
                        busy     <= 1'b0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        if (rise) begin
                            if (edge_cnt == CNT_MAX) begin
                                sat <= 1'b1;
                            end else begin
                                edge_cnt <= edge_cnt + 1'b1;
                            end
                        end
                        if (gate_cnt == GATE_LAST) begin
                            state <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    freq_out <= edge_cnt;
                    ovf      <= sat;
                    done     <= 1'b1;
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    state    <= en ? GATE : IDLE;
                    busy     <= en;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
